// File: rtl/sram_pkg.sv
// Shared types for the cache-side SRAM requester: FSM states, request record, word-width helper.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR,
    RESP
  } stateT;

  localparam int DEF_WIDTH           = 16;
  localparam int DEF_LOG_DEPTH       = 9;
  localparam int DEF_LOG_LINE_OFFSET = 3;

  function automatic int wordWidth(input int width, input int logLineOffset);
    return width >> logLineOffset;
  endfunction

  // Request record at the default geometry; the requester builds an equivalent at its own widths.
  typedef struct packed {
    logic                                                    write;
    logic [DEF_LOG_DEPTH-1:0]                                addr;
    logic [DEF_LOG_LINE_OFFSET-1:0]                          offset;
    logic [(DEF_WIDTH >> DEF_LOG_LINE_OFFSET)-1:0]           wdata;
  } reqT;

endpackage

// File: rtl/sram_line_buf.sv
// One-entry line buffer used when SRAM_REQ_FWD_EN is defined: address lookup,
// whole-line load from a completed read, and single-word update from a write.
module sram_line_buf
  import sram_pkg::*;
#(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [logDepth-1:0]      lookupAddr,
  output logic                     hit,
  output logic [width-1:0]         line,
  input  logic                     load,
  input  logic [logDepth-1:0]      loadAddr,
  input  logic [width-1:0]         loadLine,
  input  logic                     update,
  input  logic [logDepth-1:0]      updateAddr,
  input  logic [logLineOffset-1:0] updateOffset,
  input  logic [wordWidth(width, logLineOffset)-1:0] updateWord
);

  localparam int W     = wordWidth(width, logLineOffset);
  localparam int WORDS = 1 << logLineOffset;

  logic                validReg;
  logic [logDepth-1:0] addrReg;
  logic [W-1:0]        wordReg [WORDS];
  logic                updateHit;

  assign hit       = validReg && (addrReg == lookupAddr);
  assign updateHit = update && validReg && (addrReg == updateAddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validReg <= 1'b0;
      addrReg  <= '0;
    end else if (load) begin
      validReg <= 1'b1;
      addrReg  <= loadAddr;
    end
  end

  // Each word lane owns its storage so a write touches only the addressed word.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wordReg[gi] <= '0;
      end else if (load) begin
        wordReg[gi] <= loadLine[gi*W +: W];
      end else if (updateHit && (updateOffset == logLineOffset'(gi))) begin
        wordReg[gi] <= updateWord;
      end
    end
    assign line[gi*W +: W] = wordReg[gi];
  end

endmodule

// File: rtl/sram_requester.sv
// Single-outstanding SRAM initiator: word writes, fixed-latency line reads, ready/valid response.
// Optional SRAM_REQ_FWD_EN adds a one-entry line buffer that short-circuits repeat reads.
module sram_requester
  import sram_pkg::*;
#(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3,
  parameter int READ_LAT      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [logDepth-1:0]      req_addr,
  input  logic [logLineOffset-1:0] req_offset,
  input  logic [wordWidth(width, logLineOffset)-1:0] req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [width-1:0]         resp_data,
  output logic                     wr_done,
  output logic [logDepth-1:0]      sram_readAddr,
  output logic [logDepth-1:0]      sram_writeAddr,
  output logic [width-1:0]         sram_writeData,
  output logic [logLineOffset-1:0] sram_writeOffset,
  output logic                     sram_writeEnable,
  output logic                     sram_writeConfirm,
  input  logic [width-1:0]         sram_readData
);

  localparam int W  = wordWidth(width, logLineOffset);
  localparam int CW = $clog2(READ_LAT + 1);

  typedef struct packed {
    logic [logDepth-1:0]      addr;
    logic [logLineOffset-1:0] offset;
    logic [W-1:0]             wdata;
  } latchT;

  stateT             state;
  latchT             latched;
  logic [CW-1:0]     count;
  logic [width-1:0]  respLine;
  logic              readyReg;
  logic              respValidReg;
  logic              wrDoneReg;
  logic              wrEnReg;
  logic              fwdHit;
  logic [width-1:0]  fwdLine;

`ifdef SRAM_REQ_FWD_EN
  logic loadBuf;

  assign loadBuf = (state == RD_WAIT) && (count == CW'(1));

  sram_line_buf #(
    .width         (width),
    .logDepth      (logDepth),
    .logLineOffset (logLineOffset)
  ) u_lineBuf (
    .clk          (clk),
    .reset        (reset),
    .lookupAddr   (req_addr),
    .hit          (fwdHit),
    .line         (fwdLine),
    .load         (loadBuf),
    .loadAddr     (latched.addr),
    .loadLine     (sram_readData),
    .update       (wrEnReg),
    .updateAddr   (latched.addr),
    .updateOffset (latched.offset),
    .updateWord   (latched.wdata)
  );
`else
  assign fwdHit  = 1'b0;
  assign fwdLine = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      latched      <= '0;
      count        <= '0;
      respLine     <= '0;
      readyReg     <= 1'b1;
      respValidReg <= 1'b0;
      wrDoneReg    <= 1'b0;
      wrEnReg      <= 1'b0;
    end else begin
      wrDoneReg <= 1'b0;
      wrEnReg   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            latched  <= '{addr: req_addr, offset: req_offset, wdata: req_wdata};
            readyReg <= 1'b0;
            if (req_write) begin
              state     <= WR;
              wrDoneReg <= 1'b1;
              wrEnReg   <= 1'b1;
            end else if (fwdHit) begin
              state        <= RESP;
              respLine     <= fwdLine;
              respValidReg <= 1'b1;
            end else begin
              state <= RD_WAIT;
              count <= CW'(READ_LAT);
            end
          end
        end
        RD_WAIT: begin
          count <= count - CW'(1);
          // Data is valid on the last counted cycle; capture it so resp_data holds under backpressure.
          if (count == CW'(1)) begin
            respLine     <= sram_readData;
            respValidReg <= 1'b1;
            state        <= RESP;
          end
        end
        WR: begin
          state    <= IDLE;
          readyReg <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state        <= IDLE;
            respValidReg <= 1'b0;
            readyReg     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready         = readyReg;
  assign resp_valid        = respValidReg;
  assign resp_data         = respLine;
  assign wr_done           = wrDoneReg;
  assign sram_writeEnable  = wrEnReg;
  assign sram_writeConfirm = wrEnReg;
  assign sram_readAddr     = latched.addr;
  assign sram_writeAddr    = latched.addr;
  assign sram_writeOffset  = latched.offset;
  assign sram_writeData    = {{(width - W){1'b0}}, latched.wdata} << (latched.offset * W);

endmodule

// File: tb/tb_sram_requester.sv
// Directed bench for sram_requester: two instances (READ_LAT 1 and 4), an SRAM model each,
// and a scoreboard of expected read lines. Define SRAM_REQ_FWD_EN to exercise the line buffer.
module tb_sram_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic        reqWrite  [2];
  logic [8:0]  reqAddr   [2];
  logic [2:0]  reqOffset [2];
  logic [1:0]  reqWdata  [2];
  logic        respValid [2];
  logic        respReady [2];
  logic [15:0] respData  [2];
  logic        wrDone    [2];
  logic [8:0]  rdAddr    [2];
  logic [8:0]  wrAddr    [2];
  logic [15:0] wrData    [2];
  logic [2:0]  wrOff     [2];
  logic        wrEn      [2];
  logic        wrConf    [2];
  logic [15:0] rdData    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sram_requester #(
      .width         (16),
      .logDepth      (9),
      .logLineOffset (3),
      .READ_LAT      ((gi == 0) ? 1 : 4)
    ) u_dut (
      .clk               (clk),
      .reset             (rst[gi]),
      .req_valid         (reqValid[gi]),
      .req_ready         (reqReady[gi]),
      .req_write         (reqWrite[gi]),
      .req_addr          (reqAddr[gi]),
      .req_offset        (reqOffset[gi]),
      .req_wdata         (reqWdata[gi]),
      .resp_valid        (respValid[gi]),
      .resp_ready        (respReady[gi]),
      .resp_data         (respData[gi]),
      .wr_done           (wrDone[gi]),
      .sram_readAddr     (rdAddr[gi]),
      .sram_writeAddr    (wrAddr[gi]),
      .sram_writeData    (wrData[gi]),
      .sram_writeOffset  (wrOff[gi]),
      .sram_writeEnable  (wrEn[gi]),
      .sram_writeConfirm (wrConf[gi]),
      .sram_readData     (rdData[gi])
    );
  end

  function automatic logic [15:0] initLine(input int a);
    logic [15:0] v;
    v = 16'((a * 37) + 16'h5A00);
    return (a == 5 || a == 7) ? 16'h0000 : v;
  endfunction

  // SRAM model: address held stable by the requester, so a combinational read port suffices.
  logic        memInit;
  logic [15:0] mem [2][512];
  assign rdData[0] = mem[0][rdAddr[0]];
  assign rdData[1] = mem[1][rdAddr[1]];

  always @(posedge clk) begin
    if (memInit) begin
      for (int a = 0; a < 512; a++) begin
        mem[0][a] <= initLine(a);
        mem[1][a] <= initLine(a);
      end
    end else begin
      if (wrEn[0]) mem[0][wrAddr[0]][wrOff[0]*2 +: 2] <= wrData[0][wrOff[0]*2 +: 2];
      if (wrEn[1]) mem[1][wrAddr[1]][wrOff[1]*2 +: 2] <= wrData[1][wrOff[1]*2 +: 2];
    end
  end

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [15:0] expQ [$];
  logic [15:0] refMem [2][512];
  logic        bufValid [2];
  logic [8:0]  bufAddr  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input int idx, input logic [8:0] addr, input logic [2:0] off,
                         input logic [1:0] wd);
    logic [15:0] expData;
    expData = 16'(wd) << (off * 2);
    reqValid[idx] = 1'b1; reqWrite[idx] = 1'b1;
    reqAddr[idx] = addr; reqOffset[idx] = off; reqWdata[idx] = wd;
    check("wr_req_ready", 32'(reqReady[idx]), 32'd1);
    tick();
    reqValid[idx] = 1'b0;
    check("wr_enable", 32'(wrEn[idx]), 32'd1);
    check("wr_confirm", 32'(wrConf[idx]), 32'd1);
    check("wr_done", 32'(wrDone[idx]), 32'd1);
    check("wr_data", 32'(wrData[idx]), 32'(expData));
    check("wr_addr", 32'(wrAddr[idx]), 32'(addr));
    check("wr_offset", 32'(wrOff[idx]), 32'(off));
    check("wr_busy", 32'(reqReady[idx]), 32'd0);
    refMem[idx][addr][off*2 +: 2] = wd;
    tick();
    check("wr_enable_drop", 32'(wrEn[idx]), 32'd0);
    check("wr_done_drop", 32'(wrDone[idx]), 32'd0);
    check("wr_ready_again", 32'(reqReady[idx]), 32'd1);
  endtask

  // Issues a read, waits a bounded time for resp_valid, checks latency and data,
  // holds backpressure for 'hold' cycles, and optionally completes the handshake.
  task automatic doRead(input int idx, input logic [8:0] addr, input int hold,
                        input bit handshake);
    int          lat;
    int          cyc;
    bit          hit;
    logic [15:0] exp;
    hit = 1'b0;
`ifdef SRAM_REQ_FWD_EN
    hit = bufValid[idx] && (bufAddr[idx] == addr);
`endif
    lat = hit ? 1 : (((idx == 0) ? 1 : 4) + 1);
    expQ.push_back(refMem[idx][addr]);
    reqValid[idx] = 1'b1; reqWrite[idx] = 1'b0; reqAddr[idx] = addr;
    reqOffset[idx] = 3'd0; reqWdata[idx] = 2'd0;
    check("rd_req_ready", 32'(reqReady[idx]), 32'd1);
    tick();
    reqValid[idx] = 1'b0;
    cyc = 1;
    while (!respValid[idx] && cyc < 20) begin
      check("rd_addr_hold", 32'(rdAddr[idx]), 32'(addr));
      check("rd_busy", 32'(reqReady[idx]), 32'd0);
      tick();
      cyc++;
    end
    check("resp_latency", 32'(cyc), 32'(lat));
    exp = expQ.pop_front();
    check("resp_data", 32'(respData[idx]), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      tick();
      check("bp_valid", 32'(respValid[idx]), 32'd1);
      check("bp_data", 32'(respData[idx]), 32'(exp));
      check("bp_busy", 32'(reqReady[idx]), 32'd0);
    end
    if (!hit) begin
      bufValid[idx] = 1'b1;
      bufAddr[idx]  = addr;
    end
    if (handshake) begin
      respReady[idx] = 1'b1;
      tick();
      respReady[idx] = 1'b0;
      check("resp_done", 32'(respValid[idx]), 32'd0);
      check("resp_ready_again", 32'(reqReady[idx]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; reqValid[i] = 1'b0; reqWrite[i] = 1'b0; reqAddr[i] = '0;
      reqOffset[i] = '0; reqWdata[i] = '0; respReady[i] = 1'b0;
      bufValid[i] = 1'b0; bufAddr[i] = '0;
      for (int a = 0; a < 512; a++) refMem[i][a] = initLine(a);
    end
    memInit = 1'b1;
    tick(); tick();

    for (int i = 0; i < 2; i++) begin
      check("rst_req_ready", 32'(reqReady[i]), 32'd1);
      check("rst_resp_valid", 32'(respValid[i]), 32'd0);
      check("rst_resp_data", 32'(respData[i]), 32'd0);
      check("rst_wr_done", 32'(wrDone[i]), 32'd0);
      check("rst_wr_enable", 32'(wrEn[i]), 32'd0);
      check("rst_wr_confirm", 32'(wrConf[i]), 32'd0);
      check("rst_rd_addr", 32'(rdAddr[i]), 32'd0);
      check("rst_wr_data", 32'(wrData[i]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0; memInit = 1'b0;
    tick();

    // Write then read back a word, then merge a second word into the same line.
    doWrite(0, 9'd5, 3'd2, 2'b10);
    doRead(0, 9'd5, 0, 1'b1);
    doWrite(0, 9'd5, 3'd7, 2'b01);
    doRead(0, 9'd5, 0, 1'b1);

    // Backpressure for four cycles, with a competing write held across the handshake.
    doRead(0, 9'd9, 4, 1'b0);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqAddr[0] = 9'd3;
    reqOffset[0] = 3'd1; reqWdata[0] = 2'b11;
    respReady[0] = 1'b1;
    tick();
    respReady[0] = 1'b0;
    check("no_accept_in_resp", 32'(wrDone[0]), 32'd0);
    check("ready_after_hs", 32'(reqReady[0]), 32'd1);
    tick();
    reqValid[0] = 1'b0;
    check("held_wr_done", 32'(wrDone[0]), 32'd1);
    check("held_wr_data", 32'(wrData[0]), 32'h000C);
    refMem[0][3][3:2] = 2'b11;
    tick();
    doRead(0, 9'd3, 0, 1'b1);

    // Long latency instance: address held for all four wait cycles.
    doRead(1, 9'h1AB, 1, 1'b1);

    // Reset while a read is in flight: the response must never appear.
    reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqAddr[1] = 9'h033;
    tick();
    reqValid[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    #1;
    check("midrst_resp_valid", 32'(respValid[1]), 32'd0);
    check("midrst_rd_addr", 32'(rdAddr[1]), 32'd0);
    tick();
    rst[1] = 1'b0;
    bufValid[1] = 1'b0;
    tick();
    check("midrst_ready", 32'(reqReady[1]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_resp", 32'(respValid[1]), 32'd0);
      tick();
    end
    doRead(1, 9'h033, 0, 1'b1);

    // Repeat read of a freshly written line; bypasses the SRAM when the buffer is built in.
    doRead(0, 9'd7, 0, 1'b1);
    doWrite(0, 9'd7, 3'd0, 2'b11);
    doRead(0, 9'd7, 0, 1'b1);
    doRead(0, 9'd9, 0, 1'b1);

    check("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
